// File: rtl/arbiter_rr_router.sv
// Round-robin N_IN->N_OUT word router; pop is combinational, push/data_out registered 1 cycle later.
// A full output stalls only words headed to it; ARB_PKT_COUNT_EN adds saturating per-output push counters.
module arbiter_rr_router #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int DATA_W = 12,
  parameter int DEST_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IN-1:0]          empty,
  input  logic [N_IN*DATA_W-1:0]   fifo_out,
  input  logic [N_OUT-1:0]         almost_full,
  output logic [N_IN-1:0]          pop,
  output logic [N_OUT-1:0]         push,
  output logic [DATA_W-1:0]        data_out,
  output logic                     idle
`ifdef ARB_PKT_COUNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0]   pkt_cnt
`endif
);

  localparam int PTR_W = $clog2(N_IN);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic [N_IN-1:0]    elig;
  logic [DATA_W-1:0]  gnt_word;
  logic [DEST_W-1:0]  gnt_dest;

  // Eligibility looks at each head's own destination, so one full output never blocks other inputs.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_IN; i++) begin
      elig[i] = !empty[i] && !almost_full[fifo_out[i*DATA_W + DATA_W - 1 -: DEST_W]];
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (!gnt_vld && elig[(int'(rr_ptr) + k) % N_IN]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'((int'(rr_ptr) + k) % N_IN);
      end
    end
  end

  assign gnt_word = fifo_out[int'(gnt_idx)*DATA_W +: DATA_W];
  assign gnt_dest = gnt_word[DATA_W-1 -: DEST_W];

  always_comb begin
    pop = '0;
    if (reset && gnt_vld) begin
      pop[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push     <= '0;
      data_out <= '0;
      rr_ptr   <= '0;
    end else if (gnt_vld) begin
      push     <= N_OUT'(1) << gnt_dest;
      data_out <= gnt_word;
      rr_ptr   <= (gnt_idx == PTR_W'(N_IN - 1)) ? '0 : gnt_idx + 1'b1;
    end else begin
      push     <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld)  state_nxt = ACTIVE;
      ACTIVE:  if (!gnt_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign idle = (state == IDLE);

`ifdef ARB_PKT_COUNT_EN
  logic [CNT_W-1:0] cnt [N_OUT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N_OUT; j++) cnt[j] <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (push[j] && (cnt[j] != {CNT_W{1'b1}})) cnt[j] <= cnt[j] + 1'b1;
      end
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int j = 0; j < N_OUT; j++) pkt_cnt[j*CNT_W +: CNT_W] = cnt[j];
  end
`endif

endmodule

// File: tb/tb_arbiter_rr_router.sv
// Directed-vector bench: stimulus queues expected pushes, a negedge monitor pops and compares them.
module tb_arbiter_rr_router;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 4;
  localparam int DATA_W = 12;
`ifdef ARB_PKT_COUNT_EN
  localparam int CNT_W  = 2;
`else
  localparam int CNT_W  = 8;
`endif

  localparam logic [11:0] W0A  = 12'b001010010110; // dest 0
  localparam logic [11:0] W0B  = 12'b000110010110; // dest 0
  localparam logic [11:0] W0C  = 12'b010000100101; // dest 1
  localparam logic [11:0] W_RR = 12'b100000100100; // dest 2
  localparam logic [11:0] W_B  = 12'b111010100101; // dest 3

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N_IN-1:0]          empty;
  logic [N_IN*DATA_W-1:0]   fifo_out;
  logic [N_OUT-1:0]         almost_full;
  logic [N_IN-1:0]          pop;
  logic [N_OUT-1:0]         push;
  logic [DATA_W-1:0]        data_out;
  logic                     idle;
`ifdef ARB_PKT_COUNT_EN
  logic [N_OUT*CNT_W-1:0]   pkt_cnt;
`endif

  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  logic        prev_gnt;

  arbiter_rr_router #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .DEST_W(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .empty(empty),
    .fifo_out(fifo_out),
    .almost_full(almost_full),
    .pop(pop),
    .push(push),
    .data_out(data_out),
    .idle(idle)
`ifdef ARB_PKT_COUNT_EN
    ,
    .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive just after posedge, check pop/idle at negedge, queue the push expected next cycle.
  task automatic step(input logic [3:0] e, input logic [47:0] fo, input logic [3:0] af,
                      input logic [3:0] ep, input logic [3:0] epush, input logic [11:0] ed,
                      input bit enq = 1'b1);
    @(posedge clk);
    #1;
    empty       = e;
    fifo_out    = fo;
    almost_full = af;
    @(negedge clk);
    check("pop", {44'h0, pop}, {44'h0, ep});
    check("idle", {47'h0, idle}, {47'h0, !prev_gnt});
    prev_gnt = (ep != 4'b0000);
    if (enq && epush != 4'b0000) exp_q.push_back({epush, ed});
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && push !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL push_unexpected: got push=%b data=%h, expected no push", push, data_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("push", {44'h0, push}, {44'h0, mon_e[15:12]});
        check("data_out", {36'h0, data_out}, {36'h0, mon_e[11:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    empty       = 4'b1111;
    fifo_out    = '0;
    almost_full = '0;
    prev_gnt    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pop", {44'h0, pop}, 48'h0);
    check("rst_push", {44'h0, push}, 48'h0);
    check("rst_data", {36'h0, data_out}, 48'h0);
    check("rst_idle", {47'h0, idle}, 48'h1);
    empty    = 4'b0000;
    fifo_out = {4{W_RR}};
    #1;
    check("rst_pop_forced", {44'h0, pop}, 48'h0);
    empty = 4'b1111;
    @(posedge clk);
    #1 reset = 1'b1;

    // single input 0
    step(4'b1110, {36'h0, W0A}, 4'b0000, 4'b0001, 4'b0001, W0A);
    step(4'b1110, {36'h0, W0B}, 4'b0000, 4'b0001, 4'b0001, W0B);
    step(4'b1110, {36'h0, W0C}, 4'b0000, 4'b0001, 4'b0010, W0C);
    // input 3 alone moves the pointer through the wrap to 0
    step(4'b0111, {W_RR, 36'h0}, 4'b0000, 4'b1000, 4'b0100, W_RR);
    // round robin 0,1,2,3,0
    step(4'b0000, {4{W_RR}}, 4'b0000, 4'b0001, 4'b0100, W_RR);
    step(4'b0000, {4{W_RR}}, 4'b0000, 4'b0010, 4'b0100, W_RR);
    step(4'b0000, {4{W_RR}}, 4'b0000, 4'b0100, 4'b0100, W_RR);
    step(4'b0000, {4{W_RR}}, 4'b0000, 4'b1000, 4'b0100, W_RR);
    step(4'b0000, {4{W_RR}}, 4'b0000, 4'b0001, 4'b0100, W_RR);
    // all empty
    step(4'b1111, {4{W_RR}}, 4'b0000, 4'b0000, 4'b0000, 12'h0);
    // per-destination backpressure: output 2 full
    step(4'b1100, {24'h0, W_B, W_RR}, 4'b0100, 4'b0010, 4'b1000, W_B);
    step(4'b1100, {24'h0, W_B, W_RR}, 4'b0100, 4'b0010, 4'b1000, W_B);
    step(4'b1100, {24'h0, W_B, W_RR}, 4'b0100, 4'b0010, 4'b1000, W_B);
    step(4'b1100, {24'h0, W_B, W_RR}, 4'b0000, 4'b0001, 4'b0100, W_RR);
    step(4'b1100, {24'h0, W_B, W_RR}, 4'b0000, 4'b0010, 4'b1000, W_B);
    // every head blocked, then only input 0 eligible twice in a row
    step(4'b1100, {24'h0, W_B, W_RR}, 4'b1100, 4'b0000, 4'b0000, 12'h0);
    step(4'b1100, {24'h0, W_B, W_RR}, 4'b1000, 4'b0001, 4'b0100, W_RR);
    step(4'b1100, {24'h0, W_B, W_RR}, 4'b1000, 4'b0001, 4'b0100, W_RR);
    // empty rises with valid-looking data still present
    step(4'b1101, {24'h0, W_B, W_RR}, 4'b0000, 4'b0010, 4'b1000, W_B);
    step(4'b1111, {24'h0, W_B, W_RR}, 4'b0000, 4'b0000, 4'b0000, 12'h0);

    // reset in the cycle after a pop: that word is dropped
    step(4'b1011, {12'h0, W_RR, 24'h0}, 4'b0000, 4'b0100, 4'b0100, W_RR, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_push", {44'h0, push}, 48'h0);
    check("midrst_idle", {47'h0, idle}, 48'h1);
    empty    = 4'b0000;
    fifo_out = {W_RR, W_RR, W_B, W0A};
    #1;
    check("midrst_pop", {44'h0, pop}, 48'h0);
    empty = 4'b1111;
    @(posedge clk);
    #1 reset = 1'b1;
    prev_gnt = 1'b0;
    step(4'b0000, {W_RR, W_RR, W_B, W0A}, 4'b0000, 4'b0001, 4'b0001, W0A);
    step(4'b0000, {W_RR, W_RR, W_B, W0A}, 4'b0000, 4'b0010, 4'b1000, W_B);
    step(4'b1111, {W_RR, W_RR, W_B, W0A}, 4'b0000, 4'b0000, 4'b0000, 12'h0);

`ifdef ARB_PKT_COUNT_EN
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    prev_gnt = 1'b0;
    repeat (5) step(4'b1110, {36'h0, W0C}, 4'b0000, 4'b0001, 4'b0010, W0C);
    step(4'b1111, {36'h0, W0C}, 4'b0000, 4'b0000, 4'b0000, 12'h0);
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < N_OUT; j++) begin
      check($sformatf("pkt_cnt%0d", j), {46'h0, pkt_cnt[j*CNT_W +: CNT_W]},
            (j == 1) ? 48'h3 : 48'h0);
    end
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 48'(exp_q.size()), 48'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
